// File: rtl/uart_rx_fifo_writer.sv
// uart_rx_fifo_writer
// Receives 8N1 UART frames from an asynchronous serial line and writes each
// good byte into the downstream 16x8 receive FIFO. This block performs the
// only full-check on the write path, so every received byte is either
// written exactly once or reported as dropped (overrun or framing error).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   rxd        serial line, idle high, asynchronous to clk
//   full       FIFO full flag, used in the stop-sample cycle
//   wr         FIFO write strobe, one-cycle registered pulse
//   din[7:0]   byte to FIFO, registered, changes only with a wr pulse
//   frame_err  one-cycle pulse: stop bit sampled low, byte dropped
//   overrun    one-cycle pulse: good frame while full, byte dropped
//   busy       high whenever the receiver is not idle
module uart_rx_fifo_writer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       full,
    output logic       wr,
    output logic [7:0] din,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TICK_ZERO = '0;
    localparam logic [TW-1:0] TICK_ONE  = {{(TW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bitn_q, bitn_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      din_q, din_d;
    logic            wr_q, wr_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            busy_q, busy_d;
    // Two-flop synchroniser (sync1, rx_s) plus one history flop for edge detect.
    logic            sync1_q, sync1_d;
    logic            rx_s_q, rx_s_d;
    logic            rx_prev_q, rx_prev_d;

    // Next-state logic for the synchroniser, receive FSM and outcome pulses.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bitn_d      = bitn_q;
        shreg_d     = shreg_q;
        din_d       = din_q;
        wr_d        = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        sync1_d     = rxd;
        rx_s_d      = sync1_q;
        rx_prev_d   = rx_s_q;

        case (state_q)
            S_IDLE: begin
                // Requiring rx_prev high means a held-low (break) line never
                // retriggers; only a fresh falling edge starts a frame.
                if (rx_prev_q && !rx_s_q) begin
                    state_d = S_START;
                    tick_d  = TICK_ZERO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_q == TICK_HALF) begin
                    tick_d = TICK_ZERO;
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        bitn_d  = 3'd0;
                    end else begin
                        // Line went back high before mid start bit: glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            S_DATA: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = TICK_ZERO;
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    if (bitn_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bitn_d = bitn_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            S_STOP: begin
                // Leaving at mid stop bit gives half a bit of slack so a start
                // edge directly after the stop bit is still seen in IDLE.
                if (tick_q == TICK_LAST) begin
                    tick_d  = TICK_ZERO;
                    state_d = S_IDLE;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                    end else if (full) begin
                        overrun_d = 1'b1;
                    end else begin
                        wr_d  = 1'b1;
                        din_d = shreg_q;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = TICK_ZERO;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            tick_q      <= TICK_ZERO;
            bitn_q      <= 3'd0;
            shreg_q     <= 8'h00;
            din_q       <= 8'h00;
            wr_q        <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bitn_q      <= bitn_d;
            shreg_q     <= shreg_d;
            din_q       <= din_d;
            wr_q        <= wr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            rx_prev_q   <= rx_prev_d;
        end
    end

    assign wr        = wr_q;
    assign din       = din_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Scoreboard bench for uart_rx_fifo_writer: stimulus pushes the expected
// outcome of each frame; a monitor pops and compares on every output pulse.
module tb_uart_rx_fifo_writer;

    localparam int CPB = 16;
    localparam logic [1:0] K_WR = 2'd0;
    localparam logic [1:0] K_OV = 2'd1;
    localparam logic [1:0] K_FE = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       full;
    logic       wr;
    logic [7:0] din;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int   errors;
    int   checks;
    int   wr_total;
    int   fifo_base;
    int   exp_occ;
    int   cyc;
    logic [7:0] exp_din;
    exp_t exp_q[$];
    int   wr_times[$];

    uart_rx_fifo_writer #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .full      (full),
        .wr        (wr),
        .din       (din),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // FIFO model: 16 entries, never read, drained only by moving fifo_base.
    assign full = ((wr_total - fifo_base) >= 16);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog: stop a hung run with a visible failure.
    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Monitor: pop expected outcome on every pulse and compare.
    initial begin
        logic prev_pulse;
        exp_t e;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && (wr || frame_err || overrun)) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_pulse: wr=%0b fe=%0b ov=%0b din=%02h, required no pulse",
                             wr, frame_err, overrun, din);
                end else begin
                    e = exp_q.pop_front();
                    if (wr !== (e.kind == K_WR) || overrun !== (e.kind == K_OV) ||
                        frame_err !== (e.kind == K_FE) || din !== e.data) begin
                        errors = errors + 1;
                        $display("FAIL outcome: got wr=%0b ov=%0b fe=%0b din=%02h, required kind=%0d din=%02h",
                                 wr, overrun, frame_err, din, e.kind, e.data);
                    end
                end
                checks = checks + 1;
                if ((32'(wr) + 32'(frame_err) + 32'(overrun)) > 1 || prev_pulse) begin
                    errors = errors + 1;
                    $display("FAIL pulse_shape: wr=%0b fe=%0b ov=%0b prev=%0b, required single exclusive pulse",
                             wr, frame_err, overrun, prev_pulse);
                end
                if (wr) begin
                    wr_total = wr_total + 1;
                    wr_times.push_back(cyc);
                end
            end
            prev_pulse = rst && (wr || frame_err || overrun);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    // Predict the outcome of a frame from the bench's own FIFO occupancy.
    task automatic expect_frame(input logic [7:0] b, input logic stop_v);
        exp_t e;
        if (!stop_v) begin
            e.kind = K_FE; e.data = exp_din;
        end else if (exp_occ >= 16) begin
            e.kind = K_OV; e.data = exp_din;
        end else begin
            e.kind = K_WR; e.data = b; exp_din = b; exp_occ = exp_occ + 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        expect_frame(b, stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_v);
    endtask

    task automatic drain(input string name);
        idle_bits(2);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        fifo_base = wr_total;
        exp_occ   = 0;
    endtask

    initial begin
        int n0;
        int seen;
        errors = 0; checks = 0; wr_total = 0; fifo_base = 0; exp_occ = 0;
        cyc = 0; exp_din = 8'h00;
        rst = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_wr", wr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_din", din, 0);
        chk("reset_err", {frame_err, overrun}, 0);
        rst = 1'b1;
        idle_bits(2);

        // 1. single byte with busy tracking
        expect_frame(8'hA5, 1'b1);
        drive_bit(1'b0);
        chk("t1_busy_in_frame", busy, 1);
        for (int i = 0; i < 8; i++) drive_bit(n0_bit(8'hA5, i));
        drive_bit(1'b1);
        idle_bits(1);
        chk("t1_busy_after", busy, 0);
        chk("t1_din", din, 8'hA5);
        drain("t1");

        // 2. overrun: 17 back-to-back frames, no reads
        for (int k = 0; k < 17; k++) send_frame(8'(k), 1'b1);
        idle_bits(1);
        chk("t2_din_kept", din, 8'h0F);
        chk("t2_wr_count", wr_total - fifo_base, 16);
        drain("t2");

        // 3. framing error then recovery
        send_frame(8'h3C, 1'b0);
        idle_bits(1);
        send_frame(8'h55, 1'b1);
        drain("t3");

        // 4. glitch rejection
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) seen = 1;
            @(negedge clk);
        end
        chk("t4_busy_rose", seen, 1);
        repeat (CPB) @(negedge clk);
        chk("t4_busy_fell", busy, 0);
        send_frame(8'h0F, 1'b1);
        drain("t4");

        // 5. reset during data bit 3 of 0xC3
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(n0_bit(8'hC3, i));
        rxd = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_wr", wr, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_din", din, 0);
        chk("t5_rst_err", {frame_err, overrun}, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_din = 8'h00;
        idle_bits(1);
        send_frame(8'h81, 1'b1);
        drain("t5");

        // 6. zero idle gap
        n0 = wr_times.size();
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        idle_bits(1);
        chk("t6_wr_count", wr_times.size() - n0, 2);
        if (wr_times.size() - n0 == 2)
            chk("t6_gap", wr_times[n0 + 1] - wr_times[n0], 10 * CPB);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic n0_bit(input logic [7:0] b, input int i);
        return b[i];
    endfunction

endmodule
